// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and register-file geometry for the arbiter and its FIFO.
package wb_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of memory write-backs with per-entry valid bits and kill-by-address.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic                          kill,
  input  logic [REG_AW-1:0]             kill_rd,
  output wb_entry_t                     head,
  output logic [CW-1:0]                 count,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("wb_fifo: DEPTH must be a power of two and at least 2");
  end

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;

  // Kill first, then pop/push; push and pop never target the same occupied slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rd == kill_rd) begin
            mem[i].valid <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + PW'(1);
      end
      if (push) begin
        mem[tail_ptr] <= push_entry;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = mem[head_ptr];
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = mem[i].valid;
      entry_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU has absolute priority, loads drain from a FIFO.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic [AW-1:0] write_address,
  output logic [DW-1:0] write_data,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_pending,
  output logic          rs2_pending,
  output logic [CW-1:0] fifo_count
);

  if (AW != REG_AW || DW != REG_DW) begin : g_width_check
    $error("wb_arbiter: AW/DW must match the register-file widths in wb_arbiter_pkg");
  end

  logic                         alu_wr;
  logic                         push;
  logic                         pop;
  wb_entry_t                    push_entry;
  wb_entry_t                    head;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;

  assign mem_ready = (fifo_count != CW'(DEPTH));
  assign alu_wr    = alu_valid && (alu_rd != REG_ZERO);
  assign push      = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign pop       = !alu_wr && (fifo_count != '0);

  // A load to the same rd as this cycle's ALU write is older in program order, so it lands dead.
  always_comb begin
    push_entry       = '0;
    push_entry.valid = !(alu_wr && (mem_rd == alu_rd));
    push_entry.rd    = mem_rd;
    push_entry.data  = mem_data;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (alu_wr),
    .kill_rd    (alu_rd),
    .head       (head),
    .count      (fifo_count),
    .entry_valid(entry_valid),
    .entry_rd   (entry_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_address <= '0;
      write_data    <= '0;
    end else if (alu_wr) begin
      write_address <= alu_rd;
      write_data    <= alu_data;
    end else if (pop && head.valid) begin
      write_address <= head.rd;
      write_data    <= head.data;
    end else begin
      write_address <= '0;
      write_data    <= '0;
    end
  end

  // The write being driven now is still in flight until the end of this cycle.
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = (write_address == rs1_addr);
    hit2 = (write_address == rs2_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i] == rs1_addr)) hit1 = 1'b1;
      if (entry_valid[i] && (entry_rd[i] == rs2_addr)) hit2 = 1'b1;
    end
    rs1_pending = (rs1_addr != REG_ZERO) && hit1;
    rs2_pending = (rs2_addr != REG_ZERO) && hit2;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of per-cycle inputs/expected outputs plus a reset sequence.
module tb_wb_arbiter;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic [2:0]  cnt;
    logic        p1;
    logic        p2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .write_address(write_address),
    .write_data   (write_data),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(int av, int ard, logic [31:0] ad, int mv, int mrd, logic [31:0] md,
                              int r1, int r2, int wa, logic [31:0] wd, int rdy, int cnt,
                              int p1, int p2);
    vec_t v;
    v.av = (av != 0);   v.ard = 5'(ard);  v.adata = ad;
    v.mv = (mv != 0);   v.mrd = 5'(mrd);  v.mdata = md;
    v.rs1 = 5'(r1);     v.rs2 = 5'(r2);
    v.wa = 5'(wa);      v.wd = wd;        v.rdy = (rdy != 0);
    v.cnt = 3'(cnt);    v.p1 = (p1 != 0); v.p2 = (p2 != 0);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [4:0] ard, logic [31:0] ad, logic mv, logic [4:0] mrd,
                       logic [31:0] md, logic [4:0] r1, logic [4:0] r2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rs1_addr = r1;  rs2_addr = r2;
  endtask

  initial begin
    // ALU write rd=3, then idle
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 32'h0, 3, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 3, 0, 3, 32'hDEADBEEF, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 3, 0, 0, 32'h0, 1, 0, 0, 0));
    // Four loads with ALU idle: stream through with count at most 1
    vecs.push_back(mk(0, 0, 32'h0, 1, 1, 32'h101, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 2, 32'h102, 0, 0, 0, 32'h0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3, 32'h103, 0, 0, 1, 32'h101, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 4, 32'h104, 0, 0, 2, 32'h102, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 3, 32'h103, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 32'h104, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    // ALU every cycle fills the FIFO; fifth load held off, then drain in order
    vecs.push_back(mk(1, 10, 32'hA0, 1, 20, 32'h200, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 11, 32'hA1, 1, 21, 32'h201, 0, 0, 10, 32'hA0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 12, 32'hA2, 1, 22, 32'h202, 0, 0, 11, 32'hA1, 1, 2, 0, 0));
    vecs.push_back(mk(1, 13, 32'hA3, 1, 23, 32'h203, 0, 0, 12, 32'hA2, 1, 3, 0, 0));
    vecs.push_back(mk(1, 14, 32'hA4, 1, 24, 32'h204, 0, 0, 13, 32'hA3, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 24, 32'h204, 20, 0, 14, 32'hA4, 0, 4, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 24, 32'h204, 0, 0, 20, 32'h200, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 22, 24, 21, 32'h201, 1, 3, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 22, 32'h202, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 23, 32'h203, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 24, 32'h204, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    // Queued load to r7 killed by a younger ALU write to r7
    vecs.push_back(mk(0, 0, 32'h0, 1, 7, 32'h11, 7, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 7, 32'h22, 0, 0, 32'h0, 7, 0, 0, 32'h0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 7, 0, 7, 32'h22, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 7, 0, 0, 32'h0, 1, 0, 0, 0));
    // Same-cycle ALU and load to r8: load enters dead
    vecs.push_back(mk(1, 8, 32'h33, 1, 8, 32'h44, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 8, 0, 8, 32'h33, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 8, 0, 0, 32'h0, 1, 0, 0, 0));
    // rd=0 from either source never writes
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h55, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h66, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    // Pending on r5 from enqueue until the cycle after write_address=5
    vecs.push_back(mk(0, 0, 32'h0, 1, 5, 32'h5, 5, 0, 0, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 9, 32'h99, 0, 0, 32'h0, 5, 0, 0, 32'h0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 5, 0, 9, 32'h99, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 5, 0, 5, 32'h5, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 5, 0, 0, 32'h0, 1, 0, 0, 0));

    // Reset state
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset wa", 32'(write_address), 32'h0);
    chk("reset wd", write_data, 32'h0);
    chk("reset cnt", 32'(fifo_count), 32'h0);
    chk("reset ready", 32'(mem_ready), 32'h1);
    chk("reset p1", 32'(rs1_pending), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].mv, vecs[i].mrd, vecs[i].mdata,
            vecs[i].rs1, vecs[i].rs2);
      #1;
      chk($sformatf("v%0d wa", i), 32'(write_address), 32'(vecs[i].wa));
      chk($sformatf("v%0d wd", i), write_data, vecs[i].wd);
      chk($sformatf("v%0d ready", i), 32'(mem_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d cnt", i), 32'(fifo_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d p1", i), 32'(rs1_pending), 32'(vecs[i].p1));
      chk($sformatf("v%0d p2", i), 32'(rs2_pending), 32'(vecs[i].p2));
    end

    // Queue three loads behind ALU traffic, then reset mid-operation
    @(negedge clk);
    drive(1'b1, 5'd15, 32'hF0, 1'b1, 5'd25, 32'h250, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd16, 32'hF1, 1'b1, 5'd26, 32'h260, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd17, 32'hF2, 1'b1, 5'd27, 32'h270, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd26, 5'd27);
    #1;
    chk("pre-reset cnt", 32'(fifo_count), 32'h3);
    chk("pre-reset wa", 32'(write_address), 32'd17);
    chk("pre-reset p1", 32'(rs1_pending), 32'h1);
    chk("pre-reset p2", 32'(rs2_pending), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async reset cnt", 32'(fifo_count), 32'h0);
    chk("async reset p1", 32'(rs1_pending), 32'h0);
    chk("async reset p2", 32'(rs2_pending), 32'h0);
    chk("async reset wa", 32'(write_address), 32'h0);
    chk("async reset ready", 32'(mem_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset%0d wa", i), 32'(write_address), 32'h0);
      chk($sformatf("post-reset%0d cnt", i), 32'(fifo_count), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
